// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu: load/store unit sitting right after decode/control.
// Takes one memory access at a time, drives a valid/ready bus, and returns
// aligned, sign/zero-extended load data for the writeback path.
// Optional build macro: LSU_TIMEOUT_EN aborts an access with an error after
// TIMEOUT_CYC cycles spent in REQ/WAIT; without it the LSU waits indefinitely.
module ysyx_25030085_lsu #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state;
   logic        rd_q;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        bus_we_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;
   logic [3:0]  bus_wstrb_q;

   logic        is_half;
   logic        is_word;
   logic        bad_op;
   logic        misaligned;
   logic        req_err;
   logic        req_nop;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
   logic [7:0]  tmo_cnt;
   logic        tmo_hit;

   // The last allowed REQ/WAIT cycle is the one where the counter shows TIMEOUT_CYC-1.
   assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYC - 1));
`endif

   // Classify the incoming request and build the byte-lane store image.
   always_comb begin
      is_half    = (mem_op[1:0] == 2'b01);
      is_word    = (mem_op[1:0] == 2'b10);
      bad_op     = (mem_op == 3'b011) || (mem_op == 3'b110) || (mem_op == 3'b111);
      misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
      req_err    = (mem_read && mem_write) || bad_op || (mem_write && mem_op[2]) || misaligned;
      req_nop    = !mem_read && !mem_write;
      st_wstrb   = 4'b0000;
      st_wdata   = wdata;
      if (mem_write) begin
         case (mem_op[1:0])
            2'b00: begin
               st_wstrb = 4'b0001 << addr[1:0];
               st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{wdata[15:0]}};
            end
            default: st_wstrb = 4'b1111;
         endcase
      end
   end

   // Pick the addressed byte/halfword out of the returned word and extend it.
   always_comb begin
      ld_byte = bus_rdata[{off_q, 3'b000} +: 8];
      ld_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
      case (op_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = bus_rdata;
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = 32'h0;
      endcase
   end

   // Access sequencer: latch the request, run one bus transaction, pulse the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_q        <= 1'b0;
         op_q        <= 3'b000;
         off_q       <= 2'b00;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         bus_wstrb_q <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt     <= 8'h0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rd_q        <= mem_read;
                  op_q        <= mem_op;
                  off_q       <= addr[1:0];
                  bus_we_q    <= mem_write;
                  bus_addr_q  <= {addr[31:2], 2'b00};
                  bus_wdata_q <= st_wdata;
                  bus_wstrb_q <= st_wstrb;
`ifdef LSU_TIMEOUT_EN
                  tmo_cnt     <= 8'h0;
`endif
                  if (req_err) begin
                     err_q   <= 1'b1;
                     rdata_q <= 32'h0;
                     state   <= RESP;
                  end else if (req_nop) begin
                     err_q   <= 1'b0;
                     rdata_q <= 32'h0;
                     state   <= RESP;
                  end else begin
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
`ifdef LSU_TIMEOUT_EN
               if (tmo_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
                  state   <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'h1;
                  if (bus_req_ready) state <= WAIT;
               end
`else
               if (bus_req_ready) state <= WAIT;
`endif
            end
            WAIT: begin
               if (bus_resp_valid) begin
                  err_q   <= bus_resp_err;
                  rdata_q <= (rd_q && !bus_resp_err) ? ld_data : 32'h0;
                  state   <= RESP;
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
                  state   <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'h1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   assign bus_req_valid = (state == REQ);
   assign resp_valid    = (state == RESP);
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;
   assign bus_we        = bus_we_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;
   assign bus_wstrb     = bus_wstrb_q;

endmodule
